// File: rtl/dm_scan_ctrl.sv
// dm_scan_ctrl -- parametrised LED dot-matrix row scanner.
//
// Scans a ROWS x COLS matrix one row at a time. Each row is driven for
// ROW_TICKS clocks. A new frame is handed over through a one-deep pending
// buffer, and it reaches the display buffer only at a frame boundary, so a
// frame is never shown half old and half new. Per-row PWM brightness is
// derived from the low bits of the row tick counter.
//
// Build option: define DM_SCROLL_EN to add i_Scroll and horizontal scrolling.
//
// Ports:
//   i_Clk     system clock
//   i_Rst     asynchronous, active-high reset
//   i_Data    frame, row r = i_Data[COLS*r +: COLS]
//   i_Load    frame-load strobe, taken only while o_Ready is high
//   i_Bright  brightness, 0 = dimmest, all-ones = full on
//   i_Scroll  (DM_SCROLL_EN only) advance the scroll offset at each frame end
//   o_Ready   pending buffer is free
//   o_DM_Row  one-hot active-high row select
//   o_DM_Col  column drive for the selected row (COL_OFF while blanked)
//   o_fDone   one-cycle pulse on the last cycle of each frame

module dm_scan_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int ROW_TICKS = 10000,
    parameter int BRIGHT_W  = 4,
    parameter bit COL_OFF   = 1'b1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [ROWS*COLS-1:0]   i_Data,
    input  logic                   i_Load,
    input  logic [BRIGHT_W-1:0]    i_Bright,
`ifdef DM_SCROLL_EN
    input  logic                   i_Scroll,
`endif
    output logic                   o_Ready,
    output logic [ROWS-1:0]        o_DM_Row,
    output logic [COLS-1:0]        o_DM_Col,
    output logic                   o_fDone
);

    localparam int TICK_W = $clog2(ROW_TICKS);
    localparam int ROW_W  = $clog2(ROWS);
`ifdef DM_SCROLL_EN
    localparam int COL_W  = $clog2(COLS);
`endif

    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [ROW_W-1:0]     row_idx_q, row_idx_d;
    logic [ROWS*COLS-1:0] disp_q, disp_d;
    logic [ROWS*COLS-1:0] pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [BRIGHT_W-1:0]  bright_q, bright_d;
`ifdef DM_SCROLL_EN
    logic [COL_W-1:0]     scroll_ofs_q, scroll_ofs_d;
    logic [COL_W-1:0]     col_src;
`endif

    logic                 row_end;
    logic                 last_row;
    logic                 frame_end;
    logic                 load_acc;
    logic                 lit;
    logic [COLS-1:0]      row_data;
    logic [COLS-1:0]      col_map;

    assign row_end   = (tick_cnt_q == TICK_W'(ROW_TICKS - 1));
    assign last_row  = (row_idx_q == ROW_W'(ROWS - 1));
    assign frame_end = row_end && last_row;
    assign load_acc  = i_Load && !pend_valid_q;

    // Next-state logic
    always_comb begin
        tick_cnt_d   = tick_cnt_q + 1'b1;
        row_idx_d    = row_idx_q;
        bright_d     = bright_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (row_end) begin
            tick_cnt_d = '0;
            row_idx_d  = last_row ? '0 : row_idx_q + 1'b1;
            bright_d   = i_Bright;
        end

        // A load needs an empty pending buffer and a swap needs a full one,
        // so the two can never fire on the same edge.
        if (load_acc) begin
            pend_d       = i_Data;
            pend_valid_d = 1'b1;
        end else if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
    end

`ifdef DM_SCROLL_EN
    always_comb begin
        scroll_ofs_d = scroll_ofs_q;
        if (frame_end && i_Scroll) begin
            scroll_ofs_d = (scroll_ofs_q == COL_W'(COLS - 1)) ? '0 : scroll_ofs_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tick_cnt_q   <= '0;
            row_idx_q    <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            bright_q     <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            row_idx_q    <= row_idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            bright_q     <= bright_d;
        end
    end

`ifdef DM_SCROLL_EN
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            scroll_ofs_q <= '0;
        end else begin
            scroll_ofs_q <= scroll_ofs_d;
        end
    end
`endif

    // Output decode: everything below is a function of registers only.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx_q == ROW_W'(r)) begin
                row_data = disp_q[COLS*r +: COLS];
            end
        end
    end

    always_comb begin
        col_map = row_data;
`ifdef DM_SCROLL_EN
        col_src = '0;
        for (int c = 0; c < COLS; c++) begin
            col_src    = COL_W'((c + int'(scroll_ofs_q)) % COLS);
            col_map[c] = row_data[col_src];
        end
`endif
    end

    // Row is lit for the first bright_q+1 ticks of every 2**BRIGHT_W window.
    assign lit = (tick_cnt_q[BRIGHT_W-1:0] <= bright_q);

    always_comb begin
        o_DM_Row = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_DM_Row[r] = (row_idx_q == ROW_W'(r));
        end
    end

    assign o_DM_Col = lit ? col_map : {COLS{COL_OFF}};
    assign o_Ready  = !pend_valid_q;
    assign o_fDone  = frame_end;

endmodule

// File: tb/tb_dm_scan_ctrl.sv
// Testbench for dm_scan_ctrl with ROWS=8, COLS=8, ROW_TICKS=20, BRIGHT_W=2.
// Reference model works from the cycle count since reset release.
module tb_dm_scan_ctrl;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int T  = 20;
    localparam int BW = 2;
    localparam int FRAME = R * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [63:0] data = '0;
    logic [1:0]  bright = '0;
    logic        scroll = 1'b0;

    logic        o_ready;
    logic [7:0]  o_row;
    logic [7:0]  o_col;
    logic        o_fdone;

    int n_pass = 0;
    int n_total = 0;

    dm_scan_ctrl #(
        .ROWS(R), .COLS(C), .ROW_TICKS(T), .BRIGHT_W(BW), .COL_OFF(1'b1)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Data(data),
        .i_Load(load),
        .i_Bright(bright),
`ifdef DM_SCROLL_EN
        .i_Scroll(scroll),
`endif
        .o_Ready(o_ready),
        .o_DM_Row(o_row),
        .o_DM_Col(o_col),
        .o_fDone(o_fdone)
    );

    always #5 clk = ~clk;

    // Reference model
    int          m_cyc;
    logic [63:0] m_disp;
    logic [63:0] m_pend;
    logic        m_pend_v;
    int          m_bright;
    int          m_ofs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc    <= 0;
            m_disp   <= '0;
            m_pend   <= '0;
            m_pend_v <= 1'b0;
            m_bright <= 0;
            m_ofs    <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc % T == T - 1) m_bright <= int'(bright);
            if (load && !m_pend_v) begin
                m_pend   <= data;
                m_pend_v <= 1'b1;
            end else if ((m_cyc % FRAME == FRAME - 1) && m_pend_v) begin
                m_disp   <= m_pend;
                m_pend_v <= 1'b0;
            end
            if ((m_cyc % FRAME == FRAME - 1) && scroll) m_ofs <= (m_ofs + 1) % C;
        end
    end

    // {ready, fdone, row one-hot, columns} expected this cycle
    function automatic logic [17:0] exp_vec();
        int row, tick;
        logic [7:0] bits, col, oh;
        row  = (m_cyc / T) % R;
        tick = m_cyc % T;
        bits = m_disp[row*C +: C];
        for (int c = 0; c < C; c++) col[c] = bits[(c + m_ofs) % C];
        if ((tick % (1 << BW)) > m_bright) col = 8'hFF;
        oh = 8'h01 << row;
        return {!m_pend_v, (m_cyc % FRAME) == (FRAME - 1), oh, col};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        scroll = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        #1;
        n_total++;
        if ({o_ready, o_fdone, o_row, o_col} !== {1'b1, 1'b0, 8'h01, 8'h00})
            $display("FAIL reset_state got=%h want=%h", {o_ready, o_fdone, o_row, o_col},
                     {1'b1, 1'b0, 8'h01, 8'h00});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({o_ready, o_fdone, o_row, o_col} !== {1'b1, 1'b0, 8'h01, 8'h00})
            $display("FAIL reset_release got=%h want=%h", {o_ready, o_fdone, o_row, o_col},
                     {1'b1, 1'b0, 8'h01, 8'h00});
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [17:0] obs, exp;
        int pulses = 0;
        int first = -1;
        do_reset();
        bright = 2'd3;
        for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL scan cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (o_fdone === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
            end
            @(negedge clk);
        end
        n_total++;
        if (pulses !== 2 || first !== FRAME - 1)
            $display("FAIL scan_fdone pulses=%0d first=%0d want 2 and %0d", pulses, first, FRAME - 1);
        else n_pass++;
    endtask

    task automatic test_load_swap();
        logic [17:0] obs, exp;
        do_reset();
        bright = 2'd3;
        for (int cyc = 0; cyc < 2 * FRAME + 20; cyc++) begin
            load = 1'b0;
            if (cyc == 30) begin load = 1'b1; data = 64'h3C00_0000_0000_00A5; end
            if (cyc == 50) begin load = 1'b1; data = 64'h1111_1111_1111_1111; end
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL load_swap cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (cyc == 159) begin
                n_total++;
                if (o_ready !== 1'b0 || o_col !== 8'h00)
                    $display("FAIL swap_before ready=%b col=%h want 0 and 00", o_ready, o_col);
                else n_pass++;
            end
            if (cyc == 160 || cyc == 320) begin
                n_total++;
                if (o_ready !== 1'b1 || o_col !== 8'hA5)
                    $display("FAIL swap_row0 cyc=%0d ready=%b col=%h want 1 and a5", cyc, o_ready, o_col);
                else n_pass++;
            end
            if (cyc == 300) begin
                n_total++;
                if (o_col !== 8'h3C) $display("FAIL swap_row7 col=%h want 3c", o_col);
                else n_pass++;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_boundary_load();
        logic [17:0] obs, exp;
        do_reset();
        bright = 2'd3;
        for (int cyc = 0; cyc < 2 * FRAME + 20; cyc++) begin
            load = 1'b0;
            if (cyc == FRAME - 1) begin load = 1'b1; data = 64'h0000_0000_0000_005A; end
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL boundary cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (cyc == 160 || cyc == 320) begin
                n_total++;
                if (o_col !== ((cyc == 320) ? 8'h5A : 8'h00))
                    $display("FAIL boundary_show cyc=%0d col=%h", cyc, o_col);
                else n_pass++;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_pwm();
        logic [17:0] obs, exp;
        int n_lit = 0;
        do_reset();
        bright = 2'd0;
        for (int cyc = 0; cyc < FRAME + 60; cyc++) begin
            load = 1'b0;
            if (cyc == 0) begin load = 1'b1; data = '1; end
            if (cyc == 25) bright = 2'd3;
            if (cyc == 45) bright = 2'd1;
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL pwm cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (cyc < T && o_col === 8'h00) n_lit++;
            if (cyc == 26 || cyc == 42) begin
                n_total++;
                if (o_col !== ((cyc == 26) ? 8'hFF : 8'h00))
                    $display("FAIL pwm_bright_change cyc=%0d col=%h", cyc, o_col);
                else n_pass++;
            end
            @(negedge clk);
        end
        load = 1'b0;
        n_total++;
        if (n_lit !== T / 4) $display("FAIL pwm_duty lit=%0d want %0d", n_lit, T / 4);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [17:0] obs, exp;
        do_reset();
        bright = 2'd3;
        for (int cyc = 0; cyc < 90; cyc++) begin
            load = (cyc == 10);
            data = 64'hFFEE_DDCC_BBAA_9988;
            @(negedge clk);
        end
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_ready, o_row, o_col} !== {1'b1, 8'h01, 8'h00})
            $display("FAIL async_reset got=%h want=%h", {o_ready, o_row, o_col}, {1'b1, 8'h01, 8'h00});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 2 * FRAME + 10; cyc++) begin
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL after_reset cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (cyc == FRAME) begin
                n_total++;
                if (o_col !== 8'h00) $display("FAIL pending_discard col=%h want 00", o_col);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [17:0] obs, exp;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            load = ($urandom_range(0, 7) == 0);
            data = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) bright = 2'($urandom_range(0, 3));
`ifdef DM_SCROLL_EN
            scroll = 1'($urandom_range(0, 1));
`endif
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            @(negedge clk);
        end
        load = 1'b0;
        scroll = 1'b0;
    endtask

`ifdef DM_SCROLL_EN
    task automatic test_scroll();
        logic [17:0] obs, exp;
        logic [7:0]  want;
        do_reset();
        bright = 2'd3;
        for (int cyc = 0; cyc < 5 * FRAME; cyc++) begin
            load = (cyc == 0);
            data = 64'h0000_0000_0000_0001;
            scroll = (cyc >= FRAME);
            obs = {o_ready, o_fdone, o_row, o_col};
            exp = exp_vec();
            n_total++;
            if (obs !== exp) $display("FAIL scroll cyc=%0d got=%h want=%h", cyc, obs, exp);
            else n_pass++;
            if (cyc % FRAME == 0 && cyc >= FRAME) begin
                want = (cyc == FRAME) ? 8'h01 : (8'h80 >> (cyc / FRAME - 2));
                n_total++;
                if (o_col !== want) $display("FAIL scroll_row0 cyc=%0d col=%h want=%h", cyc, o_col, want);
                else n_pass++;
            end
            @(negedge clk);
        end
        load = 1'b0;
        scroll = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_load_swap();
        test_boundary_load();
        test_pwm();
        test_async_reset();
        test_random();
`ifdef DM_SCROLL_EN
        test_scroll();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
